// File: rtl/seq_detector_pkg.sv
// Shared types and constants for the serial 1001 pattern detector.
// Latency: n/a (types and constants only).
// Backpressure: n/a (no handshake; the detector consumes one bit per clock).
package seq_detector_pkg;

  // Prefix-match progress; all four encodings are legal states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_1    = 2'd1,
    S_10   = 2'd2,
    S_100  = 2'd3
  } state_t;

  // The serial pattern being searched for, first-received bit in the MSB.
  localparam logic [3:0] PATTERN = 4'b1001;

endpackage : seq_detector_pkg

// File: rtl/seq_detector_1001_mealy.sv
// Mealy detector for the serial pattern 1001, optional overlapping matches.
// Latency: detect is combinational, high in the same cycle the final '1' is on in_bit.
// Backpressure: none; one bit is consumed on every rising clk edge.
module seq_detector_1001_mealy
  import seq_detector_pkg::*;
#(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_bit,
  output logic detect
);

  state_t r_state;
  state_t w_next_state;
  logic   w_detect;

  // State register: synchronous reset returns to IDLE, otherwise follow next-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and Mealy output decode from the registered state and the current bit.
  always_comb begin
    w_next_state = S_IDLE;
    w_detect     = 1'b0;
    unique case (r_state)
      S_IDLE: w_next_state = in_bit ? S_1 : S_IDLE;
      // A run of ones keeps the latest '1' as a candidate first bit.
      S_1:    w_next_state = in_bit ? S_1 : S_10;
      S_10:   w_next_state = in_bit ? S_1 : S_100;
      S_100: begin
        if (in_bit) begin
          w_detect = 1'b1;
          // Overlapping mode reuses the final '1' as the start of the next match.
          w_next_state = OVERLAP ? S_1 : S_IDLE;
        end else begin
          // Third zero in a row cannot be part of any match.
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_detect     = 1'b0;
      end
    endcase
    // Reset masks the flag immediately, even mid-cycle.
    if (rst) begin
      w_detect = 1'b0;
    end
  end

  assign detect = w_detect;

endmodule : seq_detector_1001_mealy

// File: tb/tb_seq_detector_1001_mealy.sv
// Directed bench for the 1001 Mealy detector, overlapping and non-overlapping builds.
// Latency: checks detect combinationally, 1 time unit after in_bit changes.
// Backpressure: n/a.
module tb_seq_detector_1001_mealy;
  import seq_detector_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_bit = 1'b0;
  logic det_ov;
  logic det_nov;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detector_1001_mealy #(.OVERLAP(1'b1)) dut_ov (
    .clk    (clk),
    .rst    (rst),
    .in_bit (in_bit),
    .detect (det_ov)
  );

  seq_detector_1001_mealy #(.OVERLAP(1'b0)) dut_nov (
    .clk    (clk),
    .rst    (rst),
    .in_bit (in_bit),
    .detect (det_nov)
  );

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one bit away from the active edge, check both builds, let the next posedge sample it.
  task automatic step(input logic b, input logic e_ov, input logic e_nov, input string tag);
    @(negedge clk);
    rst    = 1'b0;
    in_bit = b;
    #1;
    check({tag, "/ov"},  {1'b0, det_ov},  {1'b0, e_ov});
    check({tag, "/nov"}, {1'b0, det_nov}, {1'b0, e_nov});
  endtask

  // Two reset edges with in_bit=1, detect low throughout, then IDLE afterwards.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst    = 1'b1;
    in_bit = 1'b1;
    #1;
    check({tag, "/rst_a"}, {det_ov, det_nov}, 2'b00);
    @(negedge clk);
    #1;
    check({tag, "/rst_b"}, {det_ov, det_nov}, 2'b00);
    @(negedge clk);
    rst    = 1'b0;
    in_bit = 1'b0;
    #1;
    check({tag, "/st_ov"},  dut_ov.r_state,  S_IDLE);
    check({tag, "/st_nov"}, dut_nov.r_state, S_IDLE);
    check({tag, "/rst_c"}, {det_ov, det_nov}, 2'b00);
  endtask

  initial begin
    // Reset scenario
    do_reset("init");

    // Overlap stream: ov pulses at bits 4,7,14; nov at 4,14
    step(1, 0, 0, "s01"); step(0, 0, 0, "s02"); step(0, 0, 0, "s03");
    step(1, 1, 1, "s04"); step(0, 0, 0, "s05"); step(0, 0, 0, "s06");
    step(1, 1, 0, "s07"); step(0, 0, 0, "s08"); step(1, 0, 0, "s09");
    step(0, 0, 0, "s10"); step(1, 0, 0, "s11"); step(0, 0, 0, "s12");
    step(0, 0, 0, "s13"); step(1, 1, 1, "s14");

    // 1001001: ov two detects, nov one
    do_reset("r2");
    step(1, 0, 0, "n1"); step(0, 0, 0, "n2"); step(0, 0, 0, "n3");
    step(1, 1, 1, "n4"); step(0, 0, 0, "n5"); step(0, 0, 0, "n6");
    step(1, 1, 0, "n7");

    // Near miss 1010001: no detect
    do_reset("r3");
    step(1, 0, 0, "m1"); step(0, 0, 0, "m2"); step(1, 0, 0, "m3");
    step(0, 0, 0, "m4"); step(0, 0, 0, "m5"); step(0, 0, 0, "m6");
    step(1, 0, 0, "m7");

    // 10001: three zeros break the match
    do_reset("r4");
    step(1, 0, 0, "z1"); step(0, 0, 0, "z2"); step(0, 0, 0, "z3");
    step(0, 0, 0, "z4"); step(1, 0, 0, "z5");

    // 1111001: run of ones, exactly one detect
    do_reset("r5");
    step(1, 0, 0, "o1"); step(1, 0, 0, "o2"); step(1, 0, 0, "o3");
    step(1, 0, 0, "o4"); step(0, 0, 0, "o5"); step(0, 0, 0, "o6");
    step(1, 1, 1, "o7");

    // Mid-sequence reset in S_100, then a fresh match starts on the first bit
    do_reset("r6");
    step(1, 0, 0, "x1"); step(0, 0, 0, "x2"); step(0, 0, 0, "x3");
    @(negedge clk);
    rst    = 1'b1;
    in_bit = 1'b1;
    #1;
    check("x_rst_mask", {det_ov, det_nov}, 2'b00);
    step(1, 0, 0, "x4"); step(0, 0, 0, "x5"); step(0, 0, 0, "x6");
    step(1, 1, 1, "x7");

    // Combinational follow in S_100: toggle in_bit between edges
    do_reset("r7");
    step(1, 0, 0, "c1"); step(0, 0, 0, "c2"); step(0, 0, 0, "c3");
    @(negedge clk);
    in_bit = 1'b0;
    #1;
    check("c_lo_a", {det_ov, det_nov}, 2'b00);
    in_bit = 1'b1;
    #1;
    check("c_hi",   {det_ov, det_nov}, 2'b11);
    in_bit = 1'b0;
    #1;
    check("c_lo_b", {det_ov, det_nov}, 2'b00);
    @(negedge clk);
    #1;
    check("c_st_ov", dut_ov.r_state, S_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seq_detector_1001_mealy
